commit_stage: RTL and testbench
===============================

# commit_stage

In-order retirement stage sitting directly downstream of the reservation/reorder `buffer`. Each cycle it scans `entries[]` for the oldest in-flight tags and retires up to two executed, non-speculative instructions. It drives the commit-side inputs of `buffer`: `is_really_commited`, `is_commited_store` and `commited_tags`. It also performs architectural register-file writes and serialises committed stores to the data memory through a request/acknowledge handshake.

## Interface
- `BUF_SIZE_LOG`, 4 — log2 of the buffer depth. `tag_t` is `BUF_SIZE_LOG+1` bits wide.
- `BUF_SIZE`, `2**BUF_SIZE_LOG` — number of entries scanned.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — asynchronous, active-low; low forces every register to its reset value immediately.
- `entries`  in  `BUF_SIZE` × `entry_t`  — current buffer contents.
- `is_really_commited`  out  2 × 1  — slot k retires this cycle.
- `is_commited_store`  out  2 × 1  — retiring slot k is a STORE.
- `commited_tags`  out  2 × `tag_t`  — tag retired in slot k.
- `rf_we`  out  2 × 1  — registered register-file write enable.
- `rf_addr`  out  2 × 5  — register-file write address.
- `rf_data`  out  2 × 32  — register-file write data.
- `mem_req`  out  1  — store write request.
- `mem_addr`  out  32  — store address.
- `mem_wdata`  out  32  — store data.
- `mem_mode`  out  `ldst_mode_t`  — store width.
- `mem_ack`  in  1  — memory accepted the store; valid only while `mem_req` is high.
- `head_tag`  out  `tag_t`  — oldest unretired tag.
- `perf_retired`  out  64  — count of retired instructions (see Configuration).

## Operation
- **Tag 0** is reserved as "no producer".
  - `head_tag` resets to 1.
  - Increment is modulo 2^(BUF_SIZE_LOG+1) and skips 0: 31→1, and 30+2→1.
- **Candidates:** slot0 = entry with `tag==head_tag`; slot1 = entry with `tag==head_tag+1` (with 0 skipped).
  - A candidate is eligible when its `e_state==S_EXECUTED` and `speculative_tag==0`.
  - No match, or multiple matches, means not eligible (a multiple match is an assertion failure).
- **Slot0, non-STORE:** retires combinationally in the same cycle it is eligible.
- **Slot0, STORE:** retires only through the store FSM.
- **Slot1** retires only if all of the following hold:
  - slot0 retires this cycle,
  - slot0 is not a STORE,
  - slot1 is eligible,
  - slot1 is not a STORE.
- **Outputs per retiring slot:**
  - `commited_tags[k]` = that tag.
  - `is_commited_store[k]` = (Unit==STORE).
  - When a slot does not retire, all of its commit outputs are 0.
- **head_tag** advances by the number of slots retired (0/1/2) at the clock edge.
- **Register-file write:** for each retiring slot with Unit≠STORE and Dest≠0, the next edge registers `rf_we=1`, `rf_addr=Dest`, `rf_data=result`. Otherwise `rf_we=0`.
  - When both slots target the same Dest, slot1 wins; the register-file consumer applies slot1 last.
- **Store FSM**, states ST_IDLE and ST_REQ:
  - ST_IDLE → ST_REQ when slot0 is an eligible STORE. On that transition, register `mem_addr=A`, `mem_wdata=Vk`, `mem_mode=rwmm`; `mem_req` goes to 1.
  - ST_REQ holds `mem_req` and all `mem_*` values stable until `mem_ack`.
  - The cycle `mem_ack==1` in ST_REQ: slot0 retires the store (`is_really_commited[0]=1`, `is_commited_store[0]=1`), `mem_req` drops at the next edge, and the FSM returns to ST_IDLE.
  - Slot1 does not retire in that cycle.
  - While in ST_REQ, no slot retires except on the ack cycle.
  - `mem_ack` while in ST_IDLE is ignored.
- **Reset values:**
  - `head_tag=1`
  - FSM = ST_IDLE
  - `mem_req=0`, `mem_addr=0`, `mem_wdata=0`, `mem_mode=BYTE`
  - `rf_we=0`, `rf_addr=0`, `rf_data=0`
  - `perf_retired=0`
  - Commit outputs are 0 whenever reset is low.

## Timing
- Non-store retirement: 0 cycles from the entry reaching S_EXECUTED (combinational commit). `buffer` clears the entry at the next edge.
- Register-file write: 1 cycle after retirement.
- Store retirement: at least 2 cycles — entry-eligible cycle → `mem_req` next cycle → retire in the `mem_ack` cycle.
- A store waiting at the head stalls all later retirement; there is no bypass.
- A speculative entry at the head stalls until its `speculative_tag` clears, or until `buffer` flushes it (the slot then simply stays non-eligible).
- Reset asserted mid-store: `mem_req` drops asynchronously, no retirement occurs, and `head_tag` returns to 1.

## Configuration
- `COMMIT_PERF_CNT_EN`
  - Defined: `perf_retired` increments each edge by the number of slots retired (0–2) and wraps at 2^64.
  - Undefined: the counter logic is absent and `perf_retired` is tied to 0.

## Test plan
- Head tag 1 ALU (Dest=5, result=0x11) and tag 2 ALU (Dest=6, result=0x22), both executed → same cycle `is_really_commited={1,1}`, `commited_tags={1,2}`; next cycle `rf_we={1,1}`, `rf_data={0x11,0x22}`; `head_tag=3`.
- Tag 1 STORE executed (A=0x100, Vk=0xDEAD, rwmm=WORD), `mem_ack` held low 3 cycles → `mem_req` high for 4 cycles with stable addr/data; retire with `is_commited_store[0]=1` only on the ack cycle; `head_tag=2`.
- `head_tag=31`, tags 31 and 1 executed → both retire and `head_tag` becomes 2; tag 0 is never issued as a commit tag.
- Head entry executed but `speculative_tag=6'b000001` → no retirement for 5 cycles; clear the speculative tag → retires that cycle.
- Reset pulled low while in ST_REQ → `mem_req=0` immediately; after release, FSM is ST_IDLE and `head_tag=1`.
- With `COMMIT_PERF_CNT_EN`: 3 dual retires plus 1 single retire → `perf_retired=7`; without the macro it reads 0.

Source files
------------

// File: rtl/commit_stage.sv
// commit_stage: in-order retirement stage downstream of the reorder buffer.
//
// Scans the buffer for the two oldest in-flight tags (head_tag, head_tag+1 with tag 0 skipped)
// and retires up to two executed, non-speculative instructions per cycle. Non-store slot-0
// instructions retire combinationally; a store at the head is serialised to data memory via a
// two-state request/acknowledge FSM and retires only on the ack cycle. A store at the head
// blocks every later instruction.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   entries               current buffer contents (BUF_SIZE entries)
//   is_really_commited    per-slot retire strobe (combinational)
//   is_commited_store     per-slot "retiring instruction is a STORE"
//   commited_tags         per-slot retired tag (0 when the slot does not retire)
//   rf_we/rf_addr/rf_data registered register-file writes; slot 1 is applied last
//   mem_req/addr/wdata/mode, mem_ack   store request/acknowledge handshake
//   head_tag              oldest unretired tag (resets to 1)
//   perf_retired          retired-instruction counter
//
// Build option: define COMMIT_PERF_CNT_EN to include the 64-bit retire counter; otherwise
// perf_retired is tied to 0.

package commit_stage_pkg;
  localparam int unsigned BUF_SIZE_LOG = 4;

  typedef logic [BUF_SIZE_LOG:0] tag_t;
  typedef logic [5:0]            spec_tag_t;

  typedef enum logic [1:0] {S_EMPTY, S_ISSUED, S_EXECUTED}   e_state_t;
  typedef enum logic [2:0] {ALU, MUL, LOAD, STORE, BRANCH}   unit_t;
  typedef enum logic [1:0] {BYTE, HALF, WORD}                ldst_mode_t;

  typedef struct packed {
    e_state_t    e_state;
    tag_t        tag;
    unit_t       unit;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] a;
    logic [31:0] vk;
    ldst_mode_t  rwmm;
    spec_tag_t   speculative_tag;
  } entry_t;
endpackage

module commit_stage
  import commit_stage_pkg::*;
#(
  parameter int unsigned BUF_SIZE = 2 ** BUF_SIZE_LOG
) (
  input  logic        clk,
  input  logic        reset,
  input  entry_t      entries [BUF_SIZE],
  output logic [1:0]  is_really_commited,
  output logic [1:0]  is_commited_store,
  output tag_t        commited_tags [2],
  output logic [1:0]  rf_we,
  output logic [4:0]  rf_addr [2],
  output logic [31:0] rf_data [2],
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output ldst_mode_t  mem_mode,
  input  logic        mem_ack,
  output tag_t        head_tag,
  output logic [63:0] perf_retired
);

  typedef enum logic {ST_IDLE, ST_REQ} st_t;

  // Modulo increment that never produces the reserved tag 0.
  function automatic tag_t tag_inc(input tag_t t);
    tag_t n;
    n = t + tag_t'(1);
    return (n == '0) ? tag_t'(1) : n;
  endfunction

  st_t         st_q, st_d;
  tag_t        head_q, head_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  ldst_mode_t  mem_mode_q, mem_mode_d;
  logic [1:0]  rf_we_q, rf_we_d;
  logic [4:0]  rf_addr_q [2];
  logic [31:0] rf_data_q [2];

  // Candidate lookup
  tag_t        tag1;
  tag_t        cnt0, cnt1;
  e_state_t    c0_state, c1_state;
  spec_tag_t   c0_spec, c1_spec;
  unit_t       c0_unit, c1_unit;
  logic [4:0]  c0_dest, c1_dest;
  logic [31:0] c0_result, c1_result;
  logic [31:0] c0_a, c0_vk;
  ldst_mode_t  c0_rwmm;
  logic        elig0, elig1;

  always_comb begin
    tag1      = tag_inc(head_q);
    cnt0      = '0;
    cnt1      = '0;
    c0_state  = S_EMPTY;
    c1_state  = S_EMPTY;
    c0_spec   = '0;
    c1_spec   = '0;
    c0_unit   = ALU;
    c1_unit   = ALU;
    c0_dest   = '0;
    c1_dest   = '0;
    c0_result = '0;
    c1_result = '0;
    c0_a      = '0;
    c0_vk     = '0;
    c0_rwmm   = BYTE;
    for (int i = 0; i < BUF_SIZE; i++) begin
      // Empty slots may hold stale tags; they never count as a match.
      if (entries[i].e_state != S_EMPTY) begin
        if (entries[i].tag == head_q) begin
          cnt0      = cnt0 + tag_t'(1);
          c0_state  = entries[i].e_state;
          c0_spec   = entries[i].speculative_tag;
          c0_unit   = entries[i].unit;
          c0_dest   = entries[i].dest;
          c0_result = entries[i].result;
          c0_a      = entries[i].a;
          c0_vk     = entries[i].vk;
          c0_rwmm   = entries[i].rwmm;
        end
        if (entries[i].tag == tag1) begin
          cnt1      = cnt1 + tag_t'(1);
          c1_state  = entries[i].e_state;
          c1_spec   = entries[i].speculative_tag;
          c1_unit   = entries[i].unit;
          c1_dest   = entries[i].dest;
          c1_result = entries[i].result;
        end
      end
    end
    elig0 = (cnt0 == tag_t'(1)) && (c0_state == S_EXECUTED) && (c0_spec == '0);
    elig1 = (cnt1 == tag_t'(1)) && (c1_state == S_EXECUTED) && (c1_spec == '0);
  end

  // Retirement decision and store FSM
  logic [1:0] retire, ret_store;

  always_comb begin
    retire      = '0;
    ret_store   = '0;
    st_d        = st_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mode_d  = mem_mode_q;
    unique case (st_q)
      ST_IDLE: begin
        if (elig0) begin
          if (c0_unit == STORE) begin
            st_d        = ST_REQ;
            mem_req_d   = 1'b1;
            mem_addr_d  = c0_a;
            mem_wdata_d = c0_vk;
            mem_mode_d  = c0_rwmm;
          end else begin
            retire[0] = 1'b1;
            retire[1] = elig1 && (c1_unit != STORE);
          end
        end
      end
      ST_REQ: begin
        // The store at the head retires on the ack cycle; nothing retires behind it.
        if (mem_ack) begin
          retire[0]    = 1'b1;
          ret_store[0] = 1'b1;
          st_d         = ST_IDLE;
          mem_req_d    = 1'b0;
        end
      end
      default: st_d = ST_IDLE;
    endcase

    head_d = retire[1] ? tag_inc(tag1) : (retire[0] ? tag1 : head_q);

    // In ST_IDLE a slot-0 retirement is never a store.
    rf_we_d[0] = retire[0] && (st_q == ST_IDLE) && (c0_dest != '0);
    rf_we_d[1] = retire[1] && (c1_dest != '0);
  end

  always_comb begin
    is_really_commited = reset ? retire : 2'b00;
    is_commited_store  = reset ? ret_store : 2'b00;
    commited_tags[0]   = (reset && retire[0]) ? head_q : '0;
    commited_tags[1]   = (reset && retire[1]) ? tag1 : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q         <= ST_IDLE;
      head_q       <= tag_t'(1);
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_mode_q   <= BYTE;
      rf_we_q      <= '0;
      rf_addr_q[0] <= '0;
      rf_addr_q[1] <= '0;
      rf_data_q[0] <= '0;
      rf_data_q[1] <= '0;
    end else begin
      st_q        <= st_d;
      head_q      <= head_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mode_q  <= mem_mode_d;
      rf_we_q     <= rf_we_d;
      if (rf_we_d[0]) begin
        rf_addr_q[0] <= c0_dest;
        rf_data_q[0] <= c0_result;
      end
      if (rf_we_d[1]) begin
        rf_addr_q[1] <= c1_dest;
        rf_data_q[1] <= c1_result;
      end
    end
  end

`ifdef COMMIT_PERF_CNT_EN
  logic [63:0] perf_q;
  logic [1:0]  n_ret;

  assign n_ret = {1'b0, retire[0]} + {1'b0, retire[1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_q + 64'(n_ret);
    end
  end

  assign perf_retired = perf_q;
`else
  assign perf_retired = '0;
`endif

  assign head_tag   = head_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_mode   = mem_mode_q;
  assign rf_we      = rf_we_q;
  assign rf_addr[0] = rf_addr_q[0];
  assign rf_addr[1] = rf_addr_q[1];
  assign rf_data[0] = rf_data_q[0];
  assign rf_data[1] = rf_data_q[1];

  // At most one live entry may carry each candidate tag.
  a_unique_tags: assert property (@(posedge clk) disable iff (!reset)
                                  (cnt0 <= tag_t'(1)) && (cnt1 <= tag_t'(1)));

endmodule

// File: tb/tb_commit_stage.sv
module tb_commit_stage;
  import commit_stage_pkg::*;

  logic        clk;
  logic        reset;
  entry_t      ents [16];
  logic [1:0]  is_really_commited;
  logic [1:0]  is_commited_store;
  tag_t        commited_tags [2];
  logic [1:0]  rf_we;
  logic [4:0]  rf_addr [2];
  logic [31:0] rf_data [2];
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  ldst_mode_t  mem_mode;
  logic        mem_ack;
  tag_t        head_tag;
  logic [63:0] perf_retired;

  commit_stage dut (
    .clk                (clk),
    .reset              (reset),
    .entries            (ents),
    .is_really_commited (is_really_commited),
    .is_commited_store  (is_commited_store),
    .commited_tags      (commited_tags),
    .rf_we              (rf_we),
    .rf_addr            (rf_addr),
    .rf_data            (rf_data),
    .mem_req            (mem_req),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_mode           (mem_mode),
    .mem_ack            (mem_ack),
    .head_tag           (head_tag),
    .perf_retired       (perf_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_exp_ret = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_ents();
    for (int i = 0; i < 16; i++) ents[i] = '0;
  endtask

  task automatic set_ent(input int idx, input tag_t t, input unit_t u, input e_state_t s,
                         input logic [5:0] sp, input logic [4:0] d, input logic [31:0] r);
    ents[idx] = '{e_state: s, tag: t, unit: u, dest: d, result: r, a: 32'h0, vk: 32'h0,
                  rwmm: BYTE, speculative_tag: sp};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    tag_t        t0;
    unit_t       u0;
    e_state_t    s0;
    logic [5:0]  sp0;
    logic [4:0]  d0;
    logic [31:0] r0;
    tag_t        t1;
    unit_t       u1;
    e_state_t    s1;
    logic [4:0]  d1;
    logic [31:0] r1;
    logic [1:0]  ret;
    tag_t        head_after;
    logic [1:0]  we;
  } vec_t;

  vec_t vt [6];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{5'd1, ALU, S_EXECUTED, 6'd0, 5'd5, 32'h11, 5'd2, ALU, S_EXECUTED, 5'd6, 32'h22,
              2'b11, 5'd3, 2'b11};
    vt[1] = '{5'd3, ALU, S_EXECUTED, 6'd0, 5'd0, 32'h33, 5'd4, ALU, S_ISSUED, 5'd4, 32'h44,
              2'b01, 5'd4, 2'b00};
    vt[2] = '{5'd4, ALU, S_EXECUTED, 6'd1, 5'd7, 32'h77, 5'd5, ALU, S_EXECUTED, 5'd8, 32'h88,
              2'b00, 5'd4, 2'b00};
    vt[3] = '{5'd4, ALU, S_EXECUTED, 6'd0, 5'd7, 32'h77, 5'd5, STORE, S_EXECUTED, 5'd0, 32'h0,
              2'b01, 5'd5, 2'b01};
    vt[4] = '{5'd5, ALU, S_ISSUED, 6'd0, 5'd9, 32'h99, 5'd6, ALU, S_EXECUTED, 5'd10, 32'haa,
              2'b00, 5'd5, 2'b00};
    vt[5] = '{5'd5, ALU, S_EXECUTED, 6'd0, 5'd3, 32'h44, 5'd6, MUL, S_EXECUTED, 5'd3, 32'h55,
              2'b11, 5'd7, 2'b11};

    reset   = 1'b0;
    mem_ack = 1'b0;
    clear_ents();
    #12;
    chk("reset_head", head_tag, 64'd1);
    chk("reset_mem_req", mem_req, 64'd0);
    chk("reset_mem_mode", mem_mode, BYTE);
    chk("reset_rf_we", rf_we, 64'd0);
    chk("reset_perf", perf_retired, 64'd0);
    reset = 1'b1;
    step();

    for (int v = 0; v < 6; v++) begin
      clear_ents();
      set_ent(0, vt[v].t0, vt[v].u0, vt[v].s0, vt[v].sp0, vt[v].d0, vt[v].r0);
      set_ent(1, vt[v].t1, vt[v].u1, vt[v].s1, 6'd0, vt[v].d1, vt[v].r1);
      #1;
      chk($sformatf("v%0d_ret", v), is_really_commited, vt[v].ret);
      chk($sformatf("v%0d_tag0", v), commited_tags[0], vt[v].ret[0] ? vt[v].t0 : 5'd0);
      chk($sformatf("v%0d_tag1", v), commited_tags[1], vt[v].ret[1] ? vt[v].t1 : 5'd0);
      chk($sformatf("v%0d_store", v), is_commited_store, 64'd0);
      n_exp_ret += int'(vt[v].ret[0]) + int'(vt[v].ret[1]);
      step();
      chk($sformatf("v%0d_head", v), head_tag, vt[v].head_after);
      chk($sformatf("v%0d_rf_we", v), rf_we, vt[v].we);
      if (vt[v].we[0]) begin
        chk($sformatf("v%0d_rf_addr0", v), rf_addr[0], vt[v].d0);
        chk($sformatf("v%0d_rf_data0", v), rf_data[0], vt[v].r0);
      end
      if (vt[v].we[1]) begin
        chk($sformatf("v%0d_rf_addr1", v), rf_addr[1], vt[v].d1);
        chk($sformatf("v%0d_rf_data1", v), rf_data[1], vt[v].r1);
      end
    end

    // Walk head from 7 to 31 with dual retires.
    for (int k = 0; k < 12; k++) begin
      clear_ents();
      set_ent(0, tag_t'(7 + 2 * k), ALU, S_EXECUTED, 6'd0, 5'd0, 32'h0);
      set_ent(1, tag_t'(8 + 2 * k), ALU, S_EXECUTED, 6'd0, 5'd0, 32'h0);
      #1;
      chk("walk_ret", is_really_commited, 64'd3);
      n_exp_ret += 2;
      step();
    end
    chk("walk_head", head_tag, 64'd31);

    // Wrap: 31 then 1, tag 0 skipped.
    clear_ents();
    set_ent(0, 5'd31, ALU, S_EXECUTED, 6'd0, 5'd0, 32'h0);
    set_ent(1, 5'd1, ALU, S_EXECUTED, 6'd0, 5'd0, 32'h0);
    #1;
    chk("wrap_ret", is_really_commited, 64'd3);
    chk("wrap_tag0", commited_tags[0], 64'd31);
    chk("wrap_tag1", commited_tags[1], 64'd1);
    n_exp_ret += 2;
    step();
    chk("wrap_head", head_tag, 64'd2);

    // Speculative head stalls; mem_ack in idle is ignored.
    clear_ents();
    set_ent(0, 5'd2, ALU, S_EXECUTED, 6'b000001, 5'd0, 32'h0);
    mem_ack = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("spec_ret", is_really_commited, 64'd0);
      step();
      chk("spec_head", head_tag, 64'd2);
      chk("idle_ack_mem_req", mem_req, 64'd0);
    end
    mem_ack = 1'b0;
    ents[0].speculative_tag = 6'd0;
    #1;
    chk("spec_clr_ret", is_really_commited, 64'd1);
    chk("spec_clr_tag0", commited_tags[0], 64'd2);
    n_exp_ret += 1;
    step();
    chk("spec_clr_head", head_tag, 64'd3);

    // Store with three stalled ack cycles; tag 4 behind it must wait.
    clear_ents();
    set_ent(0, 5'd3, STORE, S_EXECUTED, 6'd0, 5'd0, 32'h0);
    ents[0].a    = 32'h100;
    ents[0].vk   = 32'hDEAD;
    ents[0].rwmm = WORD;
    set_ent(1, 5'd4, ALU, S_EXECUTED, 6'd0, 5'd0, 32'h0);
    #1;
    chk("st_issue_ret", is_really_commited, 64'd0);
    chk("st_issue_req", mem_req, 64'd0);
    step();
    for (int c = 0; c < 3; c++) begin
      chk("st_wait_req", mem_req, 64'd1);
      chk("st_wait_addr", mem_addr, 64'h100);
      chk("st_wait_data", mem_wdata, 64'hDEAD);
      chk("st_wait_mode", mem_mode, WORD);
      chk("st_wait_ret", is_really_commited, 64'd0);
      step();
    end
    mem_ack = 1'b1;
    #1;
    chk("st_ack_req", mem_req, 64'd1);
    chk("st_ack_addr", mem_addr, 64'h100);
    chk("st_ack_ret", is_really_commited, 64'd1);
    chk("st_ack_store", is_commited_store, 64'd1);
    chk("st_ack_tag0", commited_tags[0], 64'd3);
    chk("st_ack_tag1", commited_tags[1], 64'd0);
    n_exp_ret += 1;
    step();
    mem_ack = 1'b0;
    ents[0] = '0;
    chk("st_done_req", mem_req, 64'd0);
    chk("st_done_head", head_tag, 64'd4);
    chk("st_done_rf_we", rf_we, 64'd0);
    #1;
    chk("st_next_ret", is_really_commited, 64'd1);
    chk("st_next_tag0", commited_tags[0], 64'd4);
    n_exp_ret += 1;
    step();
    chk("st_next_head", head_tag, 64'd5);

`ifdef COMMIT_PERF_CNT_EN
    chk("perf", perf_retired, 64'(n_exp_ret));
`else
    chk("perf", perf_retired, 64'd0);
`endif

    // Reset while a store request is outstanding.
    clear_ents();
    set_ent(0, 5'd5, STORE, S_EXECUTED, 6'd0, 5'd0, 32'h0);
    ents[0].a = 32'h200;
    step();
    chk("rst_st_req", mem_req, 64'd1);
    mem_ack = 1'b1;
    reset   = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 64'd0);
    chk("rst_ret", is_really_commited, 64'd0);
    chk("rst_head", head_tag, 64'd1);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_perf", perf_retired, 64'd0);
    step();
    reset   = 1'b1;
    mem_ack = 1'b0;
    clear_ents();
    set_ent(0, 5'd1, ALU, S_EXECUTED, 6'd0, 5'd9, 32'h99);
    #1;
    chk("post_rst_ret", is_really_commited, 64'd1);
    chk("post_rst_tag0", commited_tags[0], 64'd1);
    step();
    chk("post_rst_req", mem_req, 64'd0);
    chk("post_rst_head", head_tag, 64'd2);
    chk("post_rst_rf_we", rf_we, 64'd1);
    chk("post_rst_rf_data", rf_data[0], 64'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
